xbar_rr: RTL and testbench
==========================

Name: xbar_rr

Overview:
Parametrised N-port router crossbar and the successor to the fixed 5-port combinational crossbar. Each output has a round-robin arbiter with wormhole packet locking and a one-flit registered output stage with valid/ready handshake. The block pops the input FIFOs directly and replaces separate per-queue pop-request generation. It sits between the per-port input FIFOs and the link drivers / local sink of a NoC router.

Parameters:
NPORTS, 5, number of input and output ports (2..16).
DW, 32, flit data width in bits.
PW, $clog2(NPORTS), width of a destination port index.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_data_i  in  NPORTS*DW  head flit of each input FIFO; port i occupies bits [i*DW +: DW]
in_valid_i  in  NPORTS  input FIFO i non-empty
in_tail_i  in  NPORTS  flit at port i is the last flit of its packet
in_dest_i  in  NPORTS*PW  destination output index for the flit at port i (from route compute)
in_pop_o  out  NPORTS  pop strobe to input FIFO i; flit consumed this cycle
out_data_o  out  NPORTS*DW  registered output flit per port
out_valid_o  out  NPORTS  output register holds a flit
out_ready_i  in  NPORTS  downstream accepts the flit this cycle
drop_o  out  NPORTS  one-cycle pulse: flit at input i dropped because in_dest_i >= NPORTS

Behaviour:
- Reset (async, active-high): out_valid_o=0, out_data_o=0, in_pop_o=0, drop_o=0. Every arbiter goes to IDLE with rr pointer = NPORTS-1, so input 0 has first priority.
- in_pop_o and drop_o are combinational from registered state plus inputs. out_* outputs are registered.
- Request from input i to output o: in_valid_i[i] && in_dest_i[i]==o. Because each input targets one output, at most one output grants an input per cycle. Each input pops at most once per cycle.
- Output slot o is free when !out_valid_o[o] || out_ready_i[o].
- Arbiter state IDLE:
  - Search inputs ptr+1 .. ptr+NPORTS modulo NPORTS; the first requester wins.
  - Grant only if slot o is free.
  - On grant: load the flit into output register o, assert in_pop_o[winner].
  - If in_tail_i[winner]=0, go to LOCKED with owner=winner.
  - If tail (single-flit packet), stay IDLE and set ptr=winner.
- Arbiter state LOCKED(owner):
  - Only the owner may be granted; other requests are ignored.
  - A flit moves when the owner requests and slot o is free.
  - On the tail flit: go to IDLE, set ptr=owner.
  - Owner temporarily empty (in_valid=0): stay LOCKED, no bubble fill from other inputs.
- Output register:
  - On load: out_valid=1, out_data=flit.
  - Else if out_ready_i: out_valid=0; out_data holds its value.
  - Load with out_ready_i=1 in the same cycle gives back-to-back flits; throughput is 1 flit/cycle/output.
- Latency: flit popped in cycle t appears on out_data_o in cycle t+1.
- Invalid destination (in_dest_i >= NPORTS, possible when NPORTS is not a power of 2):
  - Flit is popped and discarded; drop_o[i]=1 for that cycle.
  - No arbiter state changes.
- U-turn (dest == own input index) is legal and arbitrated normally.
- Contention with out_ready_i=0 and a full slot: no grant, no pop, ptr unchanged.
- Reset mid-packet: all locks cleared and in-flight output flits discarded. Upstream packet recovery is out of scope.
- Pointer wrap: ptr=NPORTS-1 searches 0,1,...,NPORTS-1.

Decomposition:
- Package xbar_pkg:
  - Typedef flit_t (logic [DW-1:0]).
  - Typedef arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - Port-index constants for the 5-port instance: PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4.
- Sub-module xbar_rr_arb: one per output. Contains the rr pointer, lock state/owner, one-hot grant and slot-free gating. The top generates NPORTS instances, ORs the grants into in_pop_o, and muxes in_data_i into each output register.

Test Plan:
1. Single flit: in 2 -> out 4, tail=1, out_ready=1 -> in_pop_o[2] at cycle t; out_valid_o[4]=1 with the same data at t+1; arbiter stays IDLE, ptr=2.
2. Round-robin: inputs 0, 1, 3 all send single-flit packets to out 1, out_ready=1, reset ptr=4 -> grants in order 0, 1, 3, 0, 1, 3; one flit per cycle, no bubbles.
3. Wormhole lock: input 1 sends 4-flit packet to out 0 while input 3 also requests out 0 -> four consecutive input-1 flits, then input-3 flits; with the owner empty for 2 cycles mid-packet, input 3 is still not granted.
4. Backpressure: out_ready_i[2]=0 for 3 cycles with pending flit -> out_valid_o[2] and data held, in_pop_o=0; release -> next flit loaded in the same cycle the old one is accepted.
5. NPORTS=3, in_dest_i[0]=3 -> drop_o[0] one-cycle pulse, in_pop_o[0]=1, no out_valid change.
6. Assert rst while out 2 is LOCKED mid-packet -> out_valid_o=0 immediately; after release, input 0 wins first on a fresh contention.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and constants for the round-robin wormhole crossbar.
package xbar_pkg;

  localparam int XBAR_DW = 32;

  typedef logic [XBAR_DW-1:0] flit_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Port indices of the 5-port router instance.
  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

endpackage

// File: rtl/xbar_rr_arb.sv
// Per-output round-robin arbiter with wormhole lock; grants only when the
// output slot can take a flit this cycle.
module xbar_rr_arb
  import xbar_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req_i,
  input  logic [NPORTS-1:0] tail_i,
  input  logic              slot_free_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [PW-1:0]     gnt_idx_o
);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] cand_s;
  logic          found_s;

  // State, owner and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= PW'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Descending scan so the last hit is the requester closest after ptr.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    idx_s     = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      idx_s = PW'((int'(ptr_q) + k) % NPORTS);
      if (req_i[idx_s]) begin
        cand_s  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    case (state_q)
      ARB_IDLE: begin
        if (found_s && slot_free_i) begin
          gnt_o[cand_s] = 1'b1;
          gnt_idx_o     = cand_s;
          if (tail_i[cand_s]) begin
            ptr_d = cand_s;
          end else begin
            state_d = ARB_LOCKED;
            owner_d = cand_s;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (req_i[owner_q] && slot_free_i) begin
          gnt_o[owner_q] = 1'b1;
          gnt_idx_o      = owner_q;
          if (tail_i[owner_q]) begin
            state_d = ARB_IDLE;
            ptr_d   = owner_q;
          end else begin
            state_d = ARB_LOCKED;
          end
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/xbar_rr.sv
// N-port wormhole crossbar: pops input FIFO heads straight into one
// registered flit slot per output, arbitrated round-robin per output.
module xbar_rr
  import xbar_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int DW     = 32,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS*DW-1:0] in_data_i,
  input  logic [NPORTS-1:0]    in_valid_i,
  input  logic [NPORTS-1:0]    in_tail_i,
  input  logic [NPORTS*PW-1:0] in_dest_i,
  output logic [NPORTS-1:0]    in_pop_o,
  output logic [NPORTS*DW-1:0] out_data_o,
  output logic [NPORTS-1:0]    out_valid_o,
  input  logic [NPORTS-1:0]    out_ready_i,
  output logic [NPORTS-1:0]    drop_o
);

  logic [NPORTS*DW-1:0] out_data_q;
  logic [NPORTS-1:0]    out_valid_q;
  logic [NPORTS-1:0]    slot_free_s;
  logic [NPORTS-1:0]    drop_s;
  logic [NPORTS-1:0]    req_s     [NPORTS];
  logic [NPORTS-1:0]    gnt_s     [NPORTS];
  logic [PW-1:0]        gnt_idx_s [NPORTS];
  logic [DW-1:0]        load_s    [NPORTS];

  // Nothing moves while reset is held, so no flit is lost to a pop.
  assign slot_free_s = (~out_valid_q | out_ready_i) & {NPORTS{~rst}};

  // Request matrix, drop detection, pop strobes and output data mux.
  always_comb begin
    drop_s   = '0;
    in_pop_o = '0;
    for (int o = 0; o < NPORTS; o++) begin
      req_s[o]  = '0;
      load_s[o] = in_data_i[int'(gnt_idx_s[o])*DW +: DW];
    end
    for (int i = 0; i < NPORTS; i++) begin
      drop_s[i] = in_valid_i[i] && ~rst &&
                  ({1'b0, in_dest_i[i*PW +: PW]} >= (PW+1)'(NPORTS));
      for (int o = 0; o < NPORTS; o++) begin
        req_s[o][i] = in_valid_i[i] && (in_dest_i[i*PW +: PW] == PW'(o));
      end
    end
    in_pop_o = drop_s;
    for (int o = 0; o < NPORTS; o++) begin
      in_pop_o = in_pop_o | gnt_s[o];
    end
  end

  assign drop_o = drop_s;

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    xbar_rr_arb #(
      .NPORTS (NPORTS),
      .PW     (PW)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_s[o]),
      .tail_i      (in_tail_i),
      .slot_free_i (slot_free_s[o]),
      .gnt_o       (gnt_s[o]),
      .gnt_idx_o   (gnt_idx_s[o])
    );
  end

  // Output flit registers; data holds after the flit is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (|gnt_s[o]) begin
          out_valid_q[o]           <= 1'b1;
          out_data_q[o*DW +: DW]   <= load_s[o];
        end else if (out_ready_i[o]) begin
          out_valid_q[o] <= 1'b0;
        end else begin
          out_valid_q[o] <= out_valid_q[o];
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_xbar_rr.sv
// Scoreboard bench for xbar_rr: FIFO models feed the inputs, expected output
// flits are queued at enqueue time and compared on each output handshake.
module tb_xbar_rr;

  localparam int N   = 5;
  localparam int DW  = 32;
  localparam int PW  = 3;
  localparam int N3  = 3;
  localparam int PW3 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*DW-1:0] in_data_i;
  logic [N-1:0]    in_valid_i;
  logic [N-1:0]    in_tail_i;
  logic [N*PW-1:0] in_dest_i;
  logic [N-1:0]    in_pop_o;
  logic [N*DW-1:0] out_data_o;
  logic [N-1:0]    out_valid_o;
  logic [N-1:0]    out_ready_i;
  logic [N-1:0]    drop_o;

  logic [N3*DW-1:0] in_data3;
  logic [N3-1:0]    in_valid3;
  logic [N3-1:0]    in_tail3;
  logic [N3*PW3-1:0] in_dest3;
  logic [N3-1:0]    in_pop3;
  logic [N3*DW-1:0] out_data3;
  logic [N3-1:0]    out_valid3;
  logic [N3-1:0]    out_ready3;
  logic [N3-1:0]    drop3;

  xbar_rr #(.NPORTS(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_tail_i(in_tail_i),
    .in_dest_i(in_dest_i), .in_pop_o(in_pop_o), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .drop_o(drop_o)
  );

  xbar_rr #(.NPORTS(N3), .DW(DW)) dut3 (
    .clk(clk), .rst(rst),
    .in_data_i(in_data3), .in_valid_i(in_valid3), .in_tail_i(in_tail3),
    .in_dest_i(in_dest3), .in_pop_o(in_pop3), .out_data_o(out_data3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .drop_o(drop3)
  );

  typedef struct packed {
    logic [2:0]  port;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] f_data [N][32];
  logic [2:0]  f_dest [N][32];
  logic        f_tail [N][32];
  int          wp [N];
  int          rp [N];
  logic [N-1:0] last_pop;
  int checks = 0;
  int errors = 0;

  task automatic enq(input int p, input logic [31:0] d, input int dest, input logic t);
    f_data[p][wp[p]] = d;
    f_dest[p][wp[p]] = 3'(dest);
    f_tail[p][wp[p]] = t;
    wp[p]++;
  endtask

  task automatic expect_out(input int o, input logic [31:0] d);
    exp_q.push_back({3'(o), d});
  endtask

  function automatic bit fifos_busy();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) if (rp[i] < wp[i]) b = 1'b1;
    return b;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (rp[i] < wp[i]) begin
        in_valid_i[i]          = 1'b1;
        in_data_i[i*DW +: DW]  = f_data[i][rp[i]];
        in_dest_i[i*PW +: PW]  = f_dest[i][rp[i]];
        in_tail_i[i]           = f_tail[i][rp[i]];
      end else begin
        in_valid_i[i]          = 1'b0;
        in_data_i[i*DW +: DW]  = 32'h0;
        in_dest_i[i*PW +: PW]  = 3'd0;
        in_tail_i[i]           = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    last_pop = in_pop_o;
    checks++;
    if (drop_o !== 5'b00000) begin
      errors++;
      $display("FAIL drop5: got %b want 00000", drop_o);
    end
    for (int o = 0; o < N; o++) begin
      if (out_valid_o[o] && out_ready_i[o]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: port %0d data %h, expected no flit", o, out_data_o[o*DW +: DW]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({3'(o), out_data_o[o*DW +: DW]} !== e) begin
            errors++;
            $display("FAIL sb_flit: got port %0d data %h want port %0d data %h",
                     o, out_data_o[o*DW +: DW], e.port, e.data);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_pop[i] && rp[i] < wp[i]) rp[i]++;
  endtask

  task automatic run_until_empty(input int budget, output int n);
    n = 0;
    while ((exp_q.size() != 0 || fifos_busy()) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || fifos_busy()) begin
      errors++;
      $display("FAIL drain_timeout: %0d flits outstanding after %0d cycles, want 0", exp_q.size(), n);
    end
  endtask

  task automatic check_pop(input string name, input logic [N-1:0] want);
    checks++;
    if (last_pop !== want) begin
      errors++;
      $display("FAIL %s: in_pop got %b want %b", name, last_pop, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    exp_q.delete();
    out_ready_i = '1;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_inputs();
    #2;
    checks++;
    if (out_valid_o !== 5'b0 || out_data_o !== '0 || in_pop_o !== 5'b0 || drop_o !== 5'b0) begin
      errors++;
      $display("FAIL reset5: valid %b pop %b drop %b data %h want all zero",
               out_valid_o, in_pop_o, drop_o, out_data_o);
    end
    checks++;
    if (out_valid3 !== 3'b0 || out_data3 !== '0 || in_pop3 !== 3'b0 || drop3 !== 3'b0) begin
      errors++;
      $display("FAIL reset3: valid %b pop %b drop %b want all zero", out_valid3, in_pop3, drop3);
    end
    do_reset();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    enq(2, 32'hA5A5_0002, 4, 1'b1);
    expect_out(4, 32'hA5A5_0002);
    cycle();
    check_pop("single_pop", 5'b00100);
    checks++;
    if (out_valid_o[4] !== 1'b1 || out_data_o[4*DW +: DW] !== 32'hA5A5_0002) begin
      errors++;
      $display("FAIL single_latency: valid %b data %h want 1 a5a50002",
               out_valid_o[4], out_data_o[4*DW +: DW]);
    end
    cycle();
    // ptr now 2: input 3 must beat input 1.
    enq(1, 32'h0000_1111, 4, 1'b1);
    enq(3, 32'h0000_3333, 4, 1'b1);
    expect_out(4, 32'h0000_3333);
    expect_out(4, 32'h0000_1111);
    cycle();
    check_pop("single_ptr", 5'b01000);
    run_until_empty(20, n);
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      enq(0, 32'hB000_0000 + 32'(r), 1, 1'b1);
      enq(1, 32'hB100_0000 + 32'(r), 1, 1'b1);
      enq(3, 32'hB300_0000 + 32'(r), 1, 1'b1);
      expect_out(1, 32'hB000_0000 + 32'(r));
      expect_out(1, 32'hB100_0000 + 32'(r));
      expect_out(1, 32'hB300_0000 + 32'(r));
    end
    run_until_empty(30, n);
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL rr_throughput: drained in %0d cycles want 7", n);
    end
  endtask

  task automatic test_wormhole();
    int n;
    do_reset();
    enq(1, 32'hC100_0000, 0, 1'b0);
    enq(1, 32'hC100_0001, 0, 1'b0);
    enq(3, 32'hC300_0000, 0, 1'b1);
    enq(3, 32'hC300_0001, 0, 1'b1);
    expect_out(0, 32'hC100_0000);
    expect_out(0, 32'hC100_0001);
    cycle();
    check_pop("worm_first", 5'b00010);
    cycle();
    check_pop("worm_second", 5'b00010);
    cycle();
    check_pop("worm_gap1", 5'b00000);
    cycle();
    check_pop("worm_gap2", 5'b00000);
    checks++;
    if (out_valid_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL worm_bubble: out_valid[0] got %b want 0", out_valid_o[0]);
    end
    enq(1, 32'hC100_0002, 0, 1'b0);
    enq(1, 32'hC100_0003, 0, 1'b1);
    expect_out(0, 32'hC100_0002);
    expect_out(0, 32'hC100_0003);
    expect_out(0, 32'hC300_0000);
    expect_out(0, 32'hC300_0001);
    run_until_empty(30, n);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    out_ready_i = 5'b11011;
    enq(0, 32'hD000_0000, 2, 1'b1);
    enq(0, 32'hD000_0001, 2, 1'b1);
    expect_out(2, 32'hD000_0000);
    expect_out(2, 32'hD000_0001);
    cycle();
    check_pop("bp_load", 5'b00001);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_pop("bp_stall_pop", 5'b00000);
      checks++;
      if (out_valid_o[2] !== 1'b1 || out_data_o[2*DW +: DW] !== 32'hD000_0000) begin
        errors++;
        $display("FAIL bp_hold: valid %b data %h want 1 d0000000",
                 out_valid_o[2], out_data_o[2*DW +: DW]);
      end
    end
    out_ready_i = '1;
    cycle();
    check_pop("bp_release_pop", 5'b00001);
    checks++;
    if (out_valid_o[2] !== 1'b1 || out_data_o[2*DW +: DW] !== 32'hD000_0001) begin
      errors++;
      $display("FAIL bp_b2b: valid %b data %h want 1 d0000001",
               out_valid_o[2], out_data_o[2*DW +: DW]);
    end
    run_until_empty(10, n);
  endtask

  task automatic test_drop();
    do_reset();
    in_valid3 = 3'b001;
    in_tail3  = 3'b111;
    in_dest3  = 6'b000011;
    in_data3  = {32'h0, 32'h0, 32'hE000_DEAD};
    @(negedge clk);
    checks++;
    if (drop3 !== 3'b001 || in_pop3 !== 3'b001 || out_valid3 !== 3'b000) begin
      errors++;
      $display("FAIL drop_pulse: drop %b pop %b valid %b want 001 001 000", drop3, in_pop3, out_valid3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid3 !== 3'b000) begin
      errors++;
      $display("FAIL drop_noload: valid %b want 000", out_valid3);
    end
    in_dest3 = 6'b000001;
    in_data3 = {32'h0, 32'h0, 32'hE000_0001};
    @(negedge clk);
    checks++;
    if (drop3 !== 3'b000 || in_pop3 !== 3'b001) begin
      errors++;
      $display("FAIL drop_next: drop %b pop %b want 000 001", drop3, in_pop3);
    end
    @(posedge clk);
    #1;
    in_valid3 = 3'b000;
    checks++;
    if (out_valid3 !== 3'b010 || out_data3[DW +: DW] !== 32'hE000_0001) begin
      errors++;
      $display("FAIL drop_valid_route: valid %b data %h want 010 e0000001", out_valid3, out_data3[DW +: DW]);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    do_reset();
    enq(0, 32'hF000_0000, 2, 1'b1);
    expect_out(2, 32'hF000_0000);
    run_until_empty(10, n);
    out_ready_i = 5'b11011;
    enq(3, 32'hF300_0000, 2, 1'b0);
    enq(3, 32'hF300_0001, 2, 1'b0);
    cycle();
    check_pop("rmp_lock", 5'b01000);
    cycle();
    check_pop("rmp_stall", 5'b00000);
    checks++;
    if (out_valid_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL rmp_held: out_valid[2] got %b want 1", out_valid_o[2]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 5'b0 || out_data_o !== '0 || in_pop_o !== 5'b0) begin
      errors++;
      $display("FAIL rmp_async: valid %b pop %b want 00000 00000", out_valid_o, in_pop_o);
    end
    for (int i = 0; i < N; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    exp_q.delete();
    drive_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready_i = '1;
    enq(3, 32'hF300_00AA, 2, 1'b1);
    enq(0, 32'hF000_00AA, 2, 1'b1);
    expect_out(2, 32'hF000_00AA);
    expect_out(2, 32'hF300_00AA);
    cycle();
    check_pop("rmp_fresh", 5'b00001);
    run_until_empty(10, n);
  endtask

  initial begin
    out_ready_i = '1;
    for (int i = 0; i < N; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    in_data3   = '0;
    in_valid3  = '0;
    in_tail3   = '0;
    in_dest3   = '0;
    out_ready3 = '1;
    drive_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_drop();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
